conv_out_serializer: RTL and testbench



---
 rtl/conv_pkg.sv | 17 +
 rtl/pingpong_bank.sv | 37 +++
 rtl/conv_out_serializer.sv | 115 +++++++++++
 tb/tb_conv_out_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes, complex sample type and indata lane/channel slice helper
// for the FFT convolution datapath (connect, kernel feed, output serializer).
package conv_pkg;
   localparam int DATALEN  = 16;
   localparam int CMPLXLEN = 2*DATALEN;
   localparam int FFTCHNL  = 8;
   localparam int COUT     = 2;
   localparam int ROWS     = 8;
   localparam int ROWLEN   = FFTCHNL*COUT*CMPLXLEN;
   localparam int CW       = $clog2(COUT);
   localparam int RW       = $clog2(ROWS);
   localparam int LW       = $clog2(FFTCHNL);
   typedef logic [CMPLXLEN-1:0] cmplx_t;
   function automatic cmplx_t lane_slice(input logic [ROWLEN-1:0] row, input int lane, input int ch);
      return row[(lane*COUT+ch)*CMPLXLEN +: CMPLXLEN];
   endfunction
endpackage

// File: rtl/pingpong_bank.sv
// pingpong_bank: two-bank row store with per-bank full flags.
// Ports: wr_en/wr_bank/wr_row/wr_data write one row (the last row marks the bank full);
// free_en/free_bank clear a full flag; rd_bank/rd_row select rd_data asynchronously;
// full reports both flags. Contents survive reset; only the flags are cleared.
module pingpong_bank import conv_pkg::*; (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [RW-1:0]     wr_row,
   input  logic [ROWLEN-1:0] wr_data,
   input  logic              free_en,
   input  logic              free_bank,
   input  logic              rd_bank,
   input  logic [RW-1:0]     rd_row,
   output logic [ROWLEN-1:0] rd_data,
   output logic [1:0]        full
);
   logic [ROWLEN-1:0] mem_q [2][ROWS];
   logic [1:0]        full_q, full_d;
   logic              fill;
   assign fill    = wr_en && wr_row == RW'(ROWS-1);
   assign rd_data = mem_q[rd_bank][rd_row];
   assign full    = full_q;
   // clear applies before set so a bank freed and refilled in one cycle ends up correct
   always_comb begin
      for (int b = 0; b < 2; b++)
         full_d[b] = (fill && wr_bank == 1'(b)) || (full_q[b] && !(free_en && free_bank == 1'(b)));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) full_q <= '0;
      else     full_q <= full_d;
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_bank][wr_row] <= wr_data;
   end
endmodule

// File: rtl/conv_out_serializer.sv
// conv_out_serializer: collects ROWS row-parallel beats per frame into a ping-pong store
// and re-emits each frame pixel-serially (cout outer, row, col inner) under valid/ready.
// Ports: invalid/indata row input (no backpressure), in_ready bank-free status,
// overflow sticky drop flag, outvalid/outready handshake, outdata sample with
// outcout/outrow/outcol indices and outlast on the final beat of a frame.
module conv_out_serializer import conv_pkg::*; (
   input  logic                clk,
   input  logic                rst,
   input  logic                invalid,
   input  logic [ROWLEN-1:0]   indata,
   output logic                in_ready,
   output logic                overflow,
   output logic                outvalid,
   input  logic                outready,
   output logic [CMPLXLEN-1:0] outdata,
   output logic [CW-1:0]       outcout,
   output logic [RW-1:0]       outrow,
   output logic [LW-1:0]       outcol,
   output logic                outlast
);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t            state_q, state_d;
   logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, ovf_q, ovf_d;
   logic [RW-1:0]     wr_row_q, wr_row_d, row_q, row_d, orow_q, orow_d;
   logic [CW-1:0]     cout_q, cout_d, ocout_q, ocout_d;
   logic [LW-1:0]     col_q, col_d, ocol_q, ocol_d;
   logic              ov_q, ov_d, olast_q, olast_d, obank_q, obank_d;
   cmplx_t            od_q, od_d;
   logic [ROWLEN-1:0] rd_data;
   logic [1:0]        full;
   logic              wr_en, free_en, load, fetch, col_end, row_end, frame_end;
   pingpong_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_bank  (wr_bank_q),
      .wr_row   (wr_row_q),
      .wr_data  (indata),
      .free_en  (free_en),
      .free_bank(obank_q),
      .rd_bank  (rd_bank_q),
      .rd_row   (row_q),
      .rd_data  (rd_data),
      .full     (full)
   );
   // cout/row/col point at the next sample to fetch into the output register; the bank
   // is released only when its last sample is handshaken out, tracked via obank_q
   always_comb begin
      free_en   = ov_q && outready && olast_q;
      wr_en     = invalid && (!full[wr_bank_q] || (free_en && obank_q == wr_bank_q));
      load      = !ov_q || outready;
      fetch     = load && (state_q == STREAM || full[rd_bank_q]);
      col_end   = col_q == LW'(FFTCHNL-1);
      row_end   = row_q == RW'(ROWS-1);
      frame_end = col_end && row_end && cout_q == CW'(COUT-1);
      wr_row_d  = wr_en ? (wr_row_q == RW'(ROWS-1) ? '0 : wr_row_q + 1'b1) : wr_row_q;
      wr_bank_d = wr_bank_q ^ (wr_en && wr_row_q == RW'(ROWS-1));
      ovf_d     = ovf_q || (invalid && !wr_en);
      col_d     = fetch ? (col_end ? '0 : col_q + 1'b1) : col_q;
      row_d     = fetch && col_end ? (row_end ? '0 : row_q + 1'b1) : row_q;
      cout_d    = fetch && col_end && row_end ? (frame_end ? '0 : cout_q + 1'b1) : cout_q;
      rd_bank_d = rd_bank_q ^ (fetch && frame_end);
      state_d   = fetch && frame_end ? (full[!rd_bank_q] ? STREAM : IDLE) : fetch ? STREAM : state_q;
      ov_d      = load ? fetch : ov_q;
      od_d      = fetch ? lane_slice(rd_data, int'(col_q), int'(cout_q)) : od_q;
      ocout_d   = fetch ? cout_q : ocout_q;
      orow_d    = fetch ? row_q : orow_q;
      ocol_d    = fetch ? col_q : ocol_q;
      olast_d   = load ? fetch && frame_end : olast_q;
      obank_d   = fetch ? rd_bank_q : obank_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_bank_q <= 1'b0;
         wr_row_q  <= '0;
         rd_bank_q <= 1'b0;
         cout_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         ovf_q     <= 1'b0;
         ov_q      <= 1'b0;
         od_q      <= '0;
         ocout_q   <= '0;
         orow_q    <= '0;
         ocol_q    <= '0;
         olast_q   <= 1'b0;
         obank_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_bank_q <= wr_bank_d;
         wr_row_q  <= wr_row_d;
         rd_bank_q <= rd_bank_d;
         cout_q    <= cout_d;
         row_q     <= row_d;
         col_q     <= col_d;
         ovf_q     <= ovf_d;
         ov_q      <= ov_d;
         od_q      <= od_d;
         ocout_q   <= ocout_d;
         orow_q    <= orow_d;
         ocol_q    <= ocol_d;
         olast_q   <= olast_d;
         obank_q   <= obank_d;
      end
   end
   assign in_ready = !full[wr_bank_q];
   assign overflow = ovf_q;
   assign outvalid = ov_q;
   assign outdata  = od_q;
   assign outcout  = ocout_q;
   assign outrow   = orow_q;
   assign outcol   = ocol_q;
   assign outlast  = olast_q;
endmodule

// File: tb/tb_conv_out_serializer.sv
// tb_conv_out_serializer: scoreboard bench; a frame-level model queues expected beats
// when a frame completes and a negedge monitor compares every output handshake.
module tb_conv_out_serializer;
   import conv_pkg::*;
   typedef struct packed {
      logic [CMPLXLEN-1:0] d;
      logic [CW-1:0]       c;
      logic [RW-1:0]       r;
      logic [LW-1:0]       l;
      logic                last;
   } beat_t;
   logic                clk = 1'b0, rst = 1'b1, invalid = 1'b0, outready = 1'b1;
   logic [ROWLEN-1:0]   indata = '0;
   logic                in_ready, overflow, outvalid, outlast;
   logic [CMPLXLEN-1:0] outdata;
   logic [CW-1:0]       outcout;
   logic [RW-1:0]       outrow;
   logic [LW-1:0]       outcol;
   beat_t               sb[$];
   logic [ROWLEN-1:0]   part[$];
   beat_t               saved;
   int                  full_frames = 0, total = 0, bad = 0, hs_cnt = 0, cyc = 0, mode = 0;
   logic                m_ovf = 1'b0, exp_valid = 1'b0, stall_v = 1'b0;
   conv_out_serializer dut (
      .clk(clk), .rst(rst), .invalid(invalid), .indata(indata), .in_ready(in_ready),
      .overflow(overflow), .outvalid(outvalid), .outready(outready), .outdata(outdata),
      .outcout(outcout), .outrow(outrow), .outcol(outcol), .outlast(outlast)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   function automatic logic [ROWLEN-1:0] rnd_row();
      logic [ROWLEN-1:0] v;
      for (int k = 0; k < ROWLEN/32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction
   function automatic logic [ROWLEN-1:0] pat_row(input int r);
      logic [ROWLEN-1:0] v;
      for (int i = 0; i < FFTCHNL; i++)
         for (int c = 0; c < COUT; c++)
            v[(i*COUT+c)*CMPLXLEN +: CMPLXLEN] = {16'h0, 16'(r*16 + i*2 + c)};
      return v;
   endfunction
   // model: at most two complete frames held; a frame leaves when its last beat is taken,
   // and that release happens before the same cycle's input beat is judged
   always @(negedge clk) begin
      beat_t cur, e;
      logic [ROWLEN-1:0] row;
      cur = {outdata, outcout, outrow, outcol, outlast};
      if (rst) begin
         sb.delete();
         part.delete();
         full_frames = 0;
         m_ovf = 1'b0;
         exp_valid = 1'b0;
         stall_v = 1'b0;
      end else begin
         chk("in_ready", 64'(in_ready), 64'(full_frames < 2));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         if (exp_valid) chk("no_bubble", 64'(outvalid), 64'(1'b1));
         exp_valid = 1'b0;
         if (stall_v) chk("stall_hold", {23'h0, outvalid, cur}, {23'h0, 1'b1, saved});
         stall_v = outvalid && !outready;
         saved = cur;
         if (outvalid && outready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got %h want none", cur);
            end else begin
               e = sb.pop_front();
               chk("beat", 64'(cur), 64'(e));
               if (e.last) begin
                  full_frames--;
                  exp_valid = full_frames > 0;
               end
            end
         end
         if (invalid) begin
            if (full_frames < 2) begin
               part.push_back(indata);
               if (part.size() == ROWS) begin
                  for (int c = 0; c < COUT; c++)
                     for (int r = 0; r < ROWS; r++) begin
                        row = part[r];
                        for (int l = 0; l < FFTCHNL; l++)
                           sb.push_back({row[(l*COUT+c)*CMPLXLEN +: CMPLXLEN], CW'(c), RW'(r), LW'(l),
                                         1'(c == COUT-1 && r == ROWS-1 && l == FFTCHNL-1)});
                     end
                  part.delete();
                  full_frames++;
               end
            end else m_ovf = 1'b1;
         end
      end
   end
   task automatic beat(input logic v, input logic [ROWLEN-1:0] d);
      invalid = v;
      indata = d;
      outready = (mode == 0) || (mode == 1 && cyc % 3 == 0);
      cyc++;
      @(posedge clk);
      #1;
   endtask
   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || outvalid) && n < 3000) begin
         beat(1'b0, '0);
         n++;
      end
      chk({name, "_drain_done"}, 64'(n < 3000), 64'(1'b1));
   endtask
   task automatic do_reset();
      rst = 1'b1;
      beat(1'b0, '0);
      beat(1'b0, '0);
      rst = 1'b0;
   endtask
   initial begin
      int n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outvalid", 64'(outvalid), 64'(0));
      chk("rst_outdata", 64'(outdata), 64'(0));
      chk("rst_idx", 64'({outcout, outrow, outcol}), 64'(0));
      chk("rst_outlast", 64'(outlast), 64'(0));
      chk("rst_overflow", 64'(overflow), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      rst = 1'b0;
      mode = 0;
      for (int r = 0; r < ROWS; r++) beat(1'b1, pat_row(r));
      chk("lat_pre", 64'(outvalid), 64'(0));
      beat(1'b0, '0);
      chk("lat_first", 64'(outvalid), 64'(1));
      drain("single");
      mode = 1;
      for (int r = 0; r < ROWS; r++) beat(1'b1, rnd_row());
      drain("backpressure");
      mode = 0;
      for (int r = 0; r < ROWS; r++) beat(1'b1, rnd_row());
      for (int r = 0; r < ROWS; r++) begin
         beat(1'b1, rnd_row());
         repeat (4) beat(1'b0, '0);
      end
      drain("b2b");
      chk("b2b_overflow", 64'(overflow), 64'(0));
      mode = 2;
      for (int k = 1; k <= 3*ROWS; k++) begin
         beat(1'b1, rnd_row());
         if (k == 2*ROWS) chk("ovf_in_ready", 64'(in_ready), 64'(0));
         if (k == 2*ROWS + 1) chk("ovf_set", 64'(overflow), 64'(1));
      end
      mode = 0;
      drain("overflow");
      chk("ovf_sticky", 64'(overflow), 64'(1));
      do_reset();
      for (int k = 0; k < 2*ROWS; k++) beat(1'b1, rnd_row());
      n = 0;
      while (!(outvalid && outlast) && n < 500) begin
         beat(1'b0, '0);
         n++;
      end
      chk("refill_found_last", 64'(n < 500), 64'(1'b1));
      for (int r = 0; r < ROWS; r++) beat(1'b1, rnd_row());
      drain("refill");
      chk("refill_overflow", 64'(overflow), 64'(0));
      hs_cnt = 0;
      for (int r = 0; r < ROWS + 4; r++) beat(1'b1, rnd_row());
      n = 0;
      while (hs_cnt < 10 && n < 200) begin
         beat(1'b0, '0);
         n++;
      end
      rst = 1'b1;
      #1;
      chk("midrst_outvalid", 64'(outvalid), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      chk("midrst_outlast", 64'(outlast), 64'(0));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int r = 0; r < ROWS; r++) beat(1'b1, rnd_row());
      beat(1'b0, '0);
      chk("postrst_first_idx", 64'({outvalid, outcout, outrow, outcol}), 64'({1'b1, CW'(0), RW'(0), LW'(0)}));
      drain("postrst");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
